// File: rtl/gray_pkg.sv
// Shared types and constants for the Gray-code step monitor.
// Holds the tracking FSM state encoding and the step classification.
package gray_pkg;

    localparam int DEFAULT_WIDTH = 3;
    localparam int COUNT_WIDTH   = 8;
    localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = '1;

    typedef enum logic [1:0] {
        INIT  = 2'd0,
        TRACK = 2'd1,
        ERROR = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        STEP_NONE    = 2'd0,
        STEP_UP      = 2'd1,
        STEP_DOWN    = 2'd2,
        STEP_ILLEGAL = 2'd3
    } step_t;

endpackage

// File: rtl/gray_to_bin.sv
// Combinational reflected-Gray to binary decoder with a plain-binary bypass.
// Each binary bit is the XOR of its own Gray bit and every more significant one.
module gray_to_bin
    import gray_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] code,
    input  logic             select,
    output logic [WIDTH-1:0] bin
);

    logic [WIDTH-1:0] decoded;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        decoded = '0;
        for (int i = 0; i < WIDTH; i++) begin
            decoded[i] = ^(code >> i);
        end
        bin = select ? decoded : code;
    end

endmodule

// File: rtl/gray_step_monitor.sv
// Synchronizes an asynchronous Gray/binary code word, decodes it, and checks that
// each new value is a single up or down step from the previous one (with wrap).
module gray_step_monitor
    import gray_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] gray_in,
    input  logic             select,
    input  logic             clr_err,
    output logic [WIDTH-1:0] bin_out,
    output logic             change,
    output logic             dir,
    output logic             step_err,
    output logic [7:0]       step_count
);

    localparam logic [WIDTH-1:0] STEP_ONE = WIDTH'(1);

    logic [WIDTH-1:0] s1;
    logic [WIDTH-1:0] s2;
    logic             sel_q;
    state_t           state;

    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] delta;
    logic             moved;
    logic             sel_flip;
    step_t            step;

    state_t           state_n;
    logic             dir_n;
    logic             err_n;
    logic [7:0]       count_n;

    // Decode always uses the registered select so the mode is stable for a whole cycle.
    gray_to_bin #(
        .WIDTH (WIDTH)
    ) u_gray_to_bin (
        .code   (s2),
        .select (sel_q),
        .bin    (d)
    );

    assign moved    = (d != bin_out);
    assign delta    = d - bin_out;
    assign sel_flip = (select != sel_q);

    always_comb begin
        step = STEP_NONE;
        if (moved) begin
            if (delta == STEP_ONE) begin
                step = STEP_UP;
            end else if (delta == '1) begin
                step = STEP_DOWN;
            end else begin
                step = STEP_ILLEGAL;
            end
        end
    end

    always_comb begin
        state_n = state;
        dir_n   = dir;
        err_n   = step_err;
        count_n = step_count;

        case (state)
            INIT: begin
                state_n = TRACK;
            end
            TRACK: begin
                // A mode switch re-baselines instead of judging a step across two encodings.
                if (!sel_flip) begin
                    case (step)
                        STEP_UP: begin
                            dir_n   = 1'b1;
                            count_n = (step_count == COUNT_MAX) ? step_count : step_count + 8'd1;
                        end
                        STEP_DOWN: begin
                            dir_n   = 1'b0;
                            count_n = (step_count == COUNT_MAX) ? step_count : step_count + 8'd1;
                        end
                        STEP_ILLEGAL: begin
                            err_n   = 1'b1;
                            state_n = ERROR;
                        end
                        default: ;
                    endcase
                end
            end
            ERROR: begin
                if (clr_err) begin
                    err_n   = 1'b0;
                    state_n = INIT;
                end
            end
            default: begin
                state_n = INIT;
            end
        endcase

        if (sel_flip) begin
            state_n = INIT;
        end

        if (state_n == INIT) begin
            count_n = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1         <= '0;
            s2         <= '0;
            sel_q      <= 1'b0;
            bin_out    <= '0;
            change     <= 1'b0;
            dir        <= 1'b1;
            step_err   <= 1'b0;
            step_count <= '0;
            state      <= INIT;
        end else begin
            s1         <= gray_in;
            s2         <= s1;
            sel_q      <= select;
            bin_out    <= d;
            change     <= moved;
            dir        <= dir_n;
            step_err   <= err_n;
            step_count <= count_n;
            state      <= state_n;
        end
    end

endmodule

// File: tb/tb_gray_step_monitor.sv
// Directed self-checking bench: a cycle model pushes expected outputs when inputs
// are driven; they are popped and compared one edge later, plus hand-derived checkpoints.
module tb_gray_step_monitor;
    import gray_pkg::*;

    localparam int W   = 3;
    localparam int MOD = 1 << W;

    logic         clk;
    logic         reset;
    logic [W-1:0] gray_in;
    logic         select;
    logic         clr_err;
    logic [W-1:0] bin_out;
    logic         change;
    logic         dir;
    logic         step_err;
    logic [7:0]   step_count;

    gray_step_monitor #(
        .WIDTH (W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .gray_in    (gray_in),
        .select     (select),
        .clr_err    (clr_err),
        .bin_out    (bin_out),
        .change     (change),
        .dir        (dir),
        .step_err   (step_err),
        .step_count (step_count)
    );

    typedef struct {
        logic [W-1:0] bin;
        logic         chg;
        logic         dir;
        logic         err;
        logic [7:0]   cnt;
        state_t       st;
    } exp_t;

    exp_t exp_q[$];

    int n_assert = 0;
    int n_fail   = 0;
    int n_change = 0;

    logic [W-1:0] m_s1, m_s2, m_bin;
    logic         m_sel, m_chg, m_dir, m_err;
    int           m_cnt;
    state_t       m_st;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [W-1:0] g2b(input logic [W-1:0] g);
        logic [W-1:0] b;
        b = g;
        for (int s = 1; s < W; s++) b = b ^ (g >> s);
        return b;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic step(input logic [W-1:0] g, input logic sel, input logic clr, input logic rst);
        exp_t         e;
        logic [W-1:0] d;
        int           delta;
        state_t       nst;
        gray_in = g;
        select  = sel;
        clr_err = clr;
        reset   = rst;
        if (rst) begin
            m_s1 = '0; m_s2 = '0; m_sel = 1'b0; m_bin = '0; m_chg = 1'b0;
            m_dir = 1'b1; m_err = 1'b0; m_cnt = 0; m_st = INIT;
        end else begin
            d     = m_sel ? g2b(m_s2) : m_s2;
            delta = (int'(d) - int'(m_bin) + MOD) % MOD;
            nst   = m_st;
            if (sel != m_sel) begin
                if (m_st == ERROR && clr) m_err = 1'b0;
                nst = INIT;
            end else if (m_st == INIT) begin
                nst = TRACK;
            end else if (m_st == TRACK) begin
                if (delta == 1) begin
                    m_dir = 1'b1;
                    if (m_cnt < 255) m_cnt++;
                end else if (delta == MOD - 1) begin
                    m_dir = 1'b0;
                    if (m_cnt < 255) m_cnt++;
                end else if (delta != 0) begin
                    m_err = 1'b1;
                    nst   = ERROR;
                end
            end else if (clr) begin
                m_err = 1'b0;
                nst   = INIT;
            end
            if (nst == INIT) m_cnt = 0;
            m_chg = (d != m_bin);
            m_bin = d;
            m_s2  = m_s1;
            m_s1  = g;
            m_sel = sel;
            m_st  = nst;
        end
        e = '{bin: m_bin, chg: m_chg, dir: m_dir, err: m_err, cnt: m_cnt[7:0], st: m_st};
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check("bin_out", 32'(bin_out), 32'(e.bin));
        check("change", 32'(change), 32'(e.chg));
        check("dir", 32'(dir), 32'(e.dir));
        check("step_err", 32'(step_err), 32'(e.err));
        check("step_count", 32'(step_count), 32'(e.cnt));
        check("state", 32'(dut.state), 32'(e.st));
        if (change === 1'b1) n_change++;
    endtask

    task automatic hold(input logic [W-1:0] g, input logic sel, input int n);
        for (int i = 0; i < n; i++) step(g, sel, 1'b0, 1'b0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_bin"}, 32'(bin_out), 32'd0);
        check({tag, "_chg"}, 32'(change), 32'd0);
        check({tag, "_dir"}, 32'(dir), 32'd1);
        check({tag, "_err"}, 32'(step_err), 32'd0);
        check({tag, "_cnt"}, 32'(step_count), 32'd0);
        check({tag, "_state"}, 32'(dut.state), 32'(INIT));
        check({tag, "_s1"}, 32'(dut.s1), 32'd0);
        check({tag, "_s2"}, 32'(dut.s2), 32'd0);
        check({tag, "_selq"}, 32'(dut.sel_q), 32'd0);
    endtask

    logic [W-1:0] gray_seq [8] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100};

    initial begin
        // NOTE: inputs are driven with blocking assignments one time step after the edge.
        reset   = 1'b1;
        gray_in = '0;
        select  = 1'b0;
        clr_err = 1'b0;
        step(3'b000, 1'b0, 1'b0, 1'b1);
        step(3'b000, 1'b0, 1'b0, 1'b1);
        check_reset_values("reset");

        // Gray walk 0..7 with a latency probe on the first step
        hold(3'b000, 1'b1, 4);
        n_change = 0;
        step(3'b001, 1'b1, 1'b0, 1'b0);
        check("lat_e1", 32'(bin_out), 32'd0);
        step(3'b001, 1'b1, 1'b0, 1'b0);
        check("lat_e2", 32'(bin_out), 32'd0);
        step(3'b001, 1'b1, 1'b0, 1'b0);
        check("lat_e3_bin", 32'(bin_out), 32'd1);
        check("lat_e3_chg", 32'(change), 32'd1);
        step(3'b001, 1'b1, 1'b0, 1'b0);
        check("lat_e4_chg", 32'(change), 32'd0);
        for (int i = 2; i < 8; i++) hold(gray_seq[i], 1'b1, 4);
        check("walk_bin", 32'(bin_out), 32'd7);
        check("walk_dir", 32'(dir), 32'd1);
        check("walk_cnt", 32'(step_count), 32'd7);
        check("walk_pulses", 32'(n_change), 32'd7);

        // Wrap-around both ways
        hold(3'b000, 1'b1, 4);
        check("wrap_up_cnt", 32'(step_count), 32'd8);
        check("wrap_up_err", 32'(step_err), 32'd0);
        check("wrap_up_dir", 32'(dir), 32'd1);
        hold(3'b100, 1'b1, 4);
        check("wrap_dn_dir", 32'(dir), 32'd0);
        check("wrap_dn_cnt", 32'(step_count), 32'd9);

        // Illegal jump 1 -> 6, then clear
        hold(3'b000, 1'b1, 4);
        hold(3'b001, 1'b1, 4);
        check("pre_err_cnt", 32'(step_count), 32'd11);
        hold(3'b101, 1'b1, 4);
        check("jump_err", 32'(step_err), 32'd1);
        check("jump_state", 32'(dut.state), 32'(ERROR));
        check("jump_cnt", 32'(step_count), 32'd11);
        check("jump_bin", 32'(bin_out), 32'd6);
        step(3'b101, 1'b1, 1'b1, 1'b0);
        check("clr_err", 32'(step_err), 32'd0);
        check("clr_state", 32'(dut.state), 32'(INIT));
        check("clr_cnt", 32'(step_count), 32'd0);
        step(3'b101, 1'b1, 1'b0, 1'b0);
        check("clr_track", 32'(dut.state), 32'(TRACK));

        // Binary pass-through mode
        hold(3'b101, 1'b0, 4);
        hold(3'b100, 1'b0, 4);
        hold(3'b011, 1'b0, 4);
        hold(3'b100, 1'b0, 4);
        hold(3'b101, 1'b0, 4);
        check("bin_up_bin", 32'(bin_out), 32'd5);
        check("bin_up_dir", 32'(dir), 32'd1);
        check("bin_up_cnt", 32'(step_count), 32'd4);
        hold(3'b010, 1'b0, 4);
        check("bin_jump_err", 32'(step_err), 32'd1);
        check("bin_jump_cnt", 32'(step_count), 32'd4);
        step(3'b010, 1'b0, 1'b1, 1'b0);
        hold(3'b010, 1'b0, 3);
        hold(3'b011, 1'b0, 4);
        hold(3'b100, 1'b0, 4);
        step(3'b100, 1'b1, 1'b0, 1'b0);
        check("selflip_state", 32'(dut.state), 32'(INIT));
        check("selflip_err", 32'(step_err), 32'd0);
        step(3'b100, 1'b1, 1'b0, 1'b0);
        check("selflip_bin", 32'(bin_out), 32'd7);
        check("selflip_err2", 32'(step_err), 32'd0);
        check("selflip_track", 32'(dut.state), 32'(TRACK));

        // Saturation of the step counter, then reset mid-run
        hold(3'b100, 1'b0, 4);
        for (int i = 1; i <= 260; i++) step(3'((4 + i) % MOD), 1'b0, 1'b0, 1'b0);
        hold(3'((4 + 260) % MOD), 1'b0, 4);
        check("sat_cnt", 32'(step_count), 32'd255);
        check("sat_err", 32'(step_err), 32'd0);
        for (int i = 1; i <= 5; i++) step(3'(i), 1'b0, 1'b0, 1'b0);
        step(3'b110, 1'b1, 1'b1, 1'b1);
        check_reset_values("midreset");

        // Illegal step in the same cycle as clr_err, then reset out of ERROR
        hold(3'b000, 1'b0, 4);
        step(3'b011, 1'b0, 1'b0, 1'b0);
        step(3'b011, 1'b0, 1'b0, 1'b0);
        step(3'b011, 1'b0, 1'b1, 1'b0);
        check("race_err", 32'(step_err), 32'd1);
        check("race_state", 32'(dut.state), 32'(ERROR));
        hold(3'b011, 1'b0, 2);
        hold(3'b110, 1'b0, 4);
        check("err_track_bin", 32'(bin_out), 32'd6);
        check("err_hold", 32'(step_err), 32'd1);
        check("err_cnt_frozen", 32'(step_count), 32'd0);
        step(3'b110, 1'b0, 1'b0, 1'b1);
        check_reset_values("errreset");
        hold(3'b000, 1'b0, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
